// File: rtl/bcd_pkg.sv
//==============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the BCD conversion blocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Defaults shared with bcdtobinary so both ends agree on widths.
    localparam int DEF_BIN_W  = 8;
    localparam int DEF_DIGITS = 3;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
//==============================================================================
// Module      : bcd_add3
// Description : Double-dabble digit corrector (d >= 5 ? d + 3 : d).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= ADD3_THRESH) ? (d + 4'd3) : d;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
//==============================================================================
// Module      : binary_to_bcd_seq
// Description : Sequential shift-and-add-3 binary to packed BCD converter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [BIN_W-1:0]              in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out,
    output logic                          busy,
    output logic                          done
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BIN_W - 1);

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd_sr;
    logic [BIN_W-1:0]   r_bin_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_next;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .d (r_bcd_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .q (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Correct first, then shift the next binary MSB into the ones digit.
    assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin_sr[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            out      <= '0;
            r_bcd_sr <= '0;
            r_bin_sr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (load) begin
                        r_bin_sr <= in;
                        r_bcd_sr <= '0;
                        r_cnt    <= '0;
                        r_state  <= SHIFT;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SHIFT: begin
                    r_bcd_sr <= w_bcd_next;
                    r_bin_sr <= {r_bin_sr[BIN_W-2:0], 1'b0};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        out     <= w_bcd_next;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
//==============================================================================
// Module      : tb_binary_to_bcd_seq
// Description : Directed self-checking bench for binary_to_bcd_seq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [7:0]  din;
    logic [11:0] dout;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (din),
        .out   (dout),
        .busy  (busy),
        .done  (done)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((busy && done) !== 1'b0) begin
                bad++;
                $display("FAIL busy_done_exclusive: busy=%b done=%b, required not both high", busy, done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts sampled edges until done is seen; bounded at 30.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; din = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        total++; if (dout !== 12'h000) begin bad++; $display("FAIL reset_out: got %h want 000", dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_zero();
        int n;
        din = 8'd0; load = 1'b1;
        tick();
        load = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b want 1", busy); end
        wait_done(n);
        total++; if (n != 8) begin bad++; $display("FAIL zero_latency: got %0d want 8", n); end
        total++; if (dout !== 12'h000) begin bad++; $display("FAIL zero_out: got %h want 000", dout); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done); end
    endtask

    task automatic test_max();
        int nb = 0;
        din = 8'd255; load = 1'b1;
        tick();
        load = 1'b0;
        while (busy === 1'b1 && nb < 30) begin
            nb++;
            tick();
        end
        total++; if (nb != 8) begin bad++; $display("FAIL max_busy_cycles: got %0d want 8", nb); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL max_done: got %b want 1", done); end
        total++; if (dout !== 12'h255) begin bad++; $display("FAIL max_out: got %h want 255", dout); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_width: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignore_load();
        int n;
        din = 8'd99; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick();
        din = 8'd7; load = 1'b1;
        tick();
        load = 1'b0; din = 8'd0;
        wait_done(n);
        total++; if (n != 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", n); end
        total++; if (dout !== 12'h099) begin bad++; $display("FAIL ignore_out: got %h want 099", dout); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        logic seen = 1'b0;
        din = 8'd128; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        total++; if (dout !== 12'h000) begin bad++; $display("FAIL abort_out: got %h want 000", dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        reset = 1'b0;
        repeat (20) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got done seen=%b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        din = 8'd42; load = 1'b1;
        tick();
        wait_done(n1);
        total++; if (n1 != 8) begin bad++; $display("FAIL b2b_first_latency: got %0d want 8", n1); end
        total++; if (dout !== 12'h042) begin bad++; $display("FAIL b2b_first_out: got %h want 042", dout); end
        din = 8'd200;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        wait_done(n2);
        total++; if (n2 + 1 != 9) begin bad++; $display("FAIL b2b_spacing: got %0d want 9", n2 + 1); end
        total++; if (dout !== 12'h200) begin bad++; $display("FAIL b2b_second_out: got %h want 200", dout); end
        load = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        int n;
        string s;
        logic [11:0] exp;
        for (int v = 0; v < 256; v++) begin
            din = 8'(v); load = 1'b1;
            tick();
            load = 1'b0;
            wait_done(n);
            $sformat(s, "%0d", v);
            exp = 12'(s.atohex());
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL sweep_out v=%0d: got %h want %h", v, dout, exp);
            end
            total++;
            if (n != 8) begin
                bad++;
                $display("FAIL sweep_latency v=%0d: got %0d want 8", v, n);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_ignore_load();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
